// File: rtl/wb_initiator_seq.sv
// Wishbone classic initiator: one bus cycle per valid/ready command, with a bus
// timeout, a registered response port and a wrapping completed-transaction counter.
module wb_initiator_seq #(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_we_i,
    input  logic [3:0]       cmd_sel_i,
    input  logic [31:0]      cmd_adr_i,
    input  logic [31:0]      cmd_dat_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [31:0]      rsp_dat_o,
    output logic             rsp_err_o,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [3:0]       wbm_sel_o,
    output logic [31:0]      wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    input  logic             wbm_ack_i,
    input  logic [31:0]      wbm_dat_i,
    output logic             busy_o,
    output logic [CNT_W-1:0] txn_count_o
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUS  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             cyc_q, cyc_d;
    logic             we_q, we_d;
    logic [3:0]       sel_q, sel_d;
    logic [31:0]      adr_q, adr_d;
    logic [31:0]      dat_q, dat_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_err_q, rsp_err_d;
    logic [31:0]      rsp_dat_q, rsp_dat_d;
    logic [CNT_W-1:0] txn_q, txn_d;
    logic [TW-1:0]    tmo_q, tmo_d;

    // Next-state and next-output computation for the IDLE/BUS/RESP sequencer.
    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_dat_d   = rsp_dat_q;
        txn_d       = txn_q;
        tmo_d       = tmo_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    state_d = BUS;
                    cyc_d   = 1'b1;
                    we_d    = cmd_we_i;
                    sel_d   = cmd_sel_i;
                    adr_d   = {cmd_adr_i[31:2], 2'b00};
                    dat_d   = cmd_we_i ? cmd_dat_i : 32'h0000_0000;
                    tmo_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            BUS: begin
                tmo_d = tmo_q + TW'(1);
                // Ack takes priority over an expiring timeout in the same cycle.
                if (wbm_ack_i) begin
                    state_d     = RESP;
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_dat_d   = we_q ? 32'h0000_0000 : wbm_dat_i;
                    txn_d       = txn_q + CNT_W'(1);
                end else if (tmo_q == TMO_LAST) begin
                    state_d     = RESP;
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_dat_d   = 32'h0000_0000;
                end else begin
                    state_d = BUS;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d     = IDLE;
                cyc_d       = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State and registered-output flops.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q     <= IDLE;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= 4'h0;
            adr_q       <= 32'h0000_0000;
            dat_q       <= 32'h0000_0000;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_dat_q   <= 32'h0000_0000;
            txn_q       <= '0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_dat_q   <= rsp_dat_d;
            txn_q       <= txn_d;
            tmo_q       <= tmo_d;
        end
    end

    assign cmd_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_dat_o   = rsp_dat_q;
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = cyc_q;
    assign wbm_we_o    = we_q;
    assign wbm_sel_o   = sel_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;
    assign txn_count_o = txn_q;

endmodule

// File: tb/tb_wb_initiator_seq.sv
// Directed bench for wb_initiator_seq: vector table of single transactions plus
// hand sequences for response back-pressure and mid-cycle reset.
module tb_wb_initiator_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
    logic [3:0]  cmd_sel = 4'h0;
    logic [31:0] cmd_adr = 32'h0, cmd_dat = 32'h0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [31:0] rsp_dat;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic        ack = 1'b0;
    logic [31:0] rdat = 32'h0;
    logic        busy;
    logic [15:0] txn;

    int n_checks = 0;
    int n_fail   = 0;

    wb_initiator_seq #(.TIMEOUT(256), .CNT_W(16)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
        .cmd_sel_i(cmd_sel), .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat),
        .rsp_err_o(rsp_err), .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we),
        .wbm_sel_o(sel), .wbm_adr_o(adr), .wbm_dat_o(wdat), .wbm_ack_i(ack),
        .wbm_dat_i(rdat), .busy_o(busy), .txn_count_o(txn)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [31:0] rdata;
        logic [15:0] ack_cyc;   // BUS cycle (1-based) in which ack is driven; 0 = never
        logic [31:0] exp_adr;
        logic [31:0] exp_wdat;
        logic [31:0] exp_rsp;
        logic        exp_err;
        logic [15:0] exp_cyc;   // cycles cyc/stb are high
        logic [15:0] exp_txn;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        int cnt;
        cnt = 0;
        chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_we = v.we; cmd_sel = v.sel; cmd_adr = v.adr; cmd_dat = v.dat;
        step();
        cmd_valid = 1'b0;
        chk("wbm_we", {31'd0, we}, {31'd0, v.we});
        chk("wbm_sel", {28'd0, sel}, {28'd0, v.sel});
        chk("wbm_dat_o", wdat, v.exp_wdat);
        chk("busy_bus", {31'd0, busy}, 32'd1);
        while (cyc && cnt < 400) begin
            cnt++;
            chk("wbm_adr", adr, v.exp_adr);
            chk("wbm_stb", {31'd0, stb}, 32'd1);
            if (cnt == int'(v.ack_cyc)) begin
                ack = 1'b1; rdat = v.rdata;
            end
            step();
            ack = 1'b0; rdat = 32'hFFFF_FFFF;
        end
        chk("cyc_cycles", cnt, {16'd0, v.exp_cyc});
        chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("rsp_dat", rsp_dat, v.exp_rsp);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, v.exp_err});
        chk("txn_count", {16'd0, txn}, {16'd0, v.exp_txn});
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("rsp_valid_clr", {31'd0, rsp_valid}, 32'd0);
        chk("busy_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{we: 1'b1, sel: 4'hF, adr: 32'h3000_0004, dat: 32'hDEAD_BEEF, rdata: 32'h5555_5555,
                    ack_cyc: 16'd2, exp_adr: 32'h3000_0004, exp_wdat: 32'hDEAD_BEEF, exp_rsp: 32'h0,
                    exp_err: 1'b0, exp_cyc: 16'd2, exp_txn: 16'd1};
        vecs[1] = '{we: 1'b0, sel: 4'hF, adr: 32'h3000_0007, dat: 32'hCAFE_F00D, rdata: 32'h1234_5678,
                    ack_cyc: 16'd1, exp_adr: 32'h3000_0004, exp_wdat: 32'h0, exp_rsp: 32'h1234_5678,
                    exp_err: 1'b0, exp_cyc: 16'd1, exp_txn: 16'd2};
        vecs[2] = '{we: 1'b0, sel: 4'h3, adr: 32'h3000_0100, dat: 32'h0, rdata: 32'hAAAA_AAAA,
                    ack_cyc: 16'd0, exp_adr: 32'h3000_0100, exp_wdat: 32'h0, exp_rsp: 32'h0,
                    exp_err: 1'b1, exp_cyc: 16'd256, exp_txn: 16'd2};
        vecs[3] = '{we: 1'b0, sel: 4'hC, adr: 32'h3000_0202, dat: 32'h0, rdata: 32'h0BAD_CAFE,
                    ack_cyc: 16'd256, exp_adr: 32'h3000_0200, exp_wdat: 32'h0, exp_rsp: 32'h0BAD_CAFE,
                    exp_err: 1'b0, exp_cyc: 16'd256, exp_txn: 16'd3};
        vecs[4] = '{we: 1'b1, sel: 4'h0, adr: 32'h3000_0013, dat: 32'h0102_0304, rdata: 32'h7777_7777,
                    ack_cyc: 16'd3, exp_adr: 32'h3000_0010, exp_wdat: 32'h0102_0304, exp_rsp: 32'h0,
                    exp_err: 1'b0, exp_cyc: 16'd3, exp_txn: 16'd4};

        #12;
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_cyc", {31'd0, cyc}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_adr", adr, 32'h0);
        chk("rst_txn", {16'd0, txn}, 32'd0);
        rst_n = 1'b1;
        step();

        // Stray ack while idle must be ignored.
        ack = 1'b1;
        step(); step();
        ack = 1'b0;
        chk("idle_ack_busy", {31'd0, busy}, 32'd0);
        chk("idle_ack_txn", {16'd0, txn}, 32'd0);

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Back-pressure on the response with a second command waiting.
        step();
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_sel = 4'hF; cmd_adr = 32'h3000_0020; cmd_dat = 32'h0;
        step();
        ack = 1'b1; rdat = 32'hA5A5_0001;
        step();
        ack = 1'b0; rdat = 32'h0;
        for (int i = 0; i < 10; i++) begin
            chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_rsp_dat", rsp_dat, 32'hA5A5_0001);
            chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("bp_idle_ready", {31'd0, cmd_ready}, 32'd1);
        chk("bp_idle_cyc", {31'd0, cyc}, 32'd0);
        step();
        chk("bp_second_cyc", {31'd0, cyc}, 32'd1);
        chk("bp_second_busy", {31'd0, busy}, 32'd1);
        cmd_valid = 1'b0;
        ack = 1'b1; rdat = 32'h0000_0042;
        step();
        ack = 1'b0;
        chk("bp_second_rsp", rsp_dat, 32'h0000_0042);
        chk("bp_txn", {16'd0, txn}, 32'd6);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // Asynchronous reset while cyc is high.
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_0040; cmd_dat = 32'h1111_2222;
        step();
        cmd_valid = 1'b0;
        chk("rst_pre_cyc", {31'd0, cyc}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cyc", {31'd0, cyc}, 32'd0);
        chk("arst_stb", {31'd0, stb}, 32'd0);
        chk("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_txn", {16'd0, txn}, 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        ack = 1'b1; rdat = 32'h9999_9999;
        step(); step();
        ack = 1'b0;
        chk("post_rst_txn", {16'd0, txn}, 32'd0);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        chk("post_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
